alu_result_stage: RTL

- Downstream neighbour of the ALU: it accepts each ALU result (RZ plus status flags) and queues it in a small FIFO.
- It presents queued results to register-file writeback through a valid/ready handshake.
- It owns the 32-bit Condition Control Register (CCR) that the ALU flag outputs feed.
- It decouples ALU timing from writeback stalls.

---
 rtl/alu_result_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// Result stage after the ALU: queues each result in a small FIFO for register-file writeback
// and maintains the Condition Control Register fed by the ALU flags.
module alu_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [DATA_WIDTH-1:0]      RZ,
  input  logic [REG_ADDR_W-1:0]      DestReg,
  input  logic                       WriteEn,
  input  logic                       NOP_FLAG,
  input  logic                       IFNR_FLAG,
  input  logic                       INR_FLAG,
  input  logic                       NEGATIVE_FLAG,
  input  logic                       ZERO_FLAG,
  input  logic                       OVERFLOW_FLAG,
  input  logic                       CARRY_FLAG,
  input  logic                       CcrClear,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [DATA_WIDTH-1:0]      WbData,
  output logic [REG_ADDR_W-1:0]      WbDest,
  output logic                       WbWrite,
  output logic [$clog2(DEPTH):0]     Count,
  output logic [31:0]                CCR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [REG_ADDR_W-1:0] dest;
    logic                  write;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            entry_in;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [6:0]        ccr_q;
  logic              push;
  logic              pop;

  assign InReady  = (Count != CNT_W'(DEPTH));
  assign OutValid = (Count != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  // Unrecognised instructions and NOPs still flow through, but never write the register file.
  assign entry_in = '{data:  RZ,
                      dest:  DestReg,
                      write: WriteEn && !NOP_FLAG && !INR_FLAG && !IFNR_FLAG};

  assign head    = mem[rd_ptr];
  assign WbData  = OutValid ? head.data  : '0;
  assign WbDest  = OutValid ? head.dest  : '0;
  assign WbWrite = OutValid ? head.write : 1'b0;

  // NOTE: storage is deliberately not reset; Count gates every output, so stale slots are never seen.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Layout: [0] C, [1] N, [2] V, [3] Z, [4] INR sticky, [5] IFNR sticky, [6] last NOP.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ccr_q <= '0;
    end else begin
      if (push && !NOP_FLAG) ccr_q[3:0] <= {ZERO_FLAG, OVERFLOW_FLAG, NEGATIVE_FLAG, CARRY_FLAG};
      if (push)              ccr_q[6]   <= NOP_FLAG;
      // A sticky set on the same edge as a clear takes priority.
      ccr_q[4] <= (ccr_q[4] && !CcrClear) || (push && INR_FLAG);
      ccr_q[5] <= (ccr_q[5] && !CcrClear) || (push && IFNR_FLAG);
    end
  end

  assign CCR = {25'd0, ccr_q};

endmodule
